plru_tree_update: RTL
=====================

Name: plru_tree_update

Overview:
- Write-side companion of the pseudo-LRU victim walker.
- On a cache hit or fill to a given way, walks the PLRU tree from root to leaf, one level per clock.
- Flips every node on the path to point away from the accessed way, then issues a single write of the new LRU vector to the LRU array.
- Sits between the cache control FSM (issues updates) and the per-set LRU storage (receives `lru_out`/`lru_we`).

Parameters:
- `s_assoc`, 8, number of ways; power of two, ≥ 2.
- `s_width`, `$clog2(s_assoc)`, way-index width and number of tree levels.

Ports:
- `clk`  input  1  clock; all state updates on posedge.
- `rst_n`  input  1  asynchronous active-low reset.
- `update_req`  input  1  request to record an access; sampled only when `update_ready`=1.
- `update_way`  input  `s_width`  accessed way, captured with the request.
- `lru_in`  input  `s_assoc-1`  current LRU bits of the target set, captured with the request.
- `abort`  input  1  cancels an in-flight update; no write is issued.
- `update_ready`  output  1  block is idle and can accept a request.
- `lru_out`  output  `s_assoc-1`  updated LRU vector; valid only while `lru_we`=1.
- `lru_we`  output  1  one-cycle write strobe to the LRU array.
- `done`  output  1  one-cycle pulse, coincident with `lru_we`.

Behaviour:
- Tree encoding, shared with the victim walker:
  - Heap-ordered nodes; root = 0.
  - Children of node p: 2p+1 (left) and 2p+2 (right).
  - Node bit 0 points the victim search left; bit 1 points it right.
- Leaf order matches way index, MSB first: at level l the path direction is `update_way[s_width-1-l]` (0 = left, 1 = right).
- Update rule on each visited node:
  - Path goes left: set node bit to 1.
  - Path goes right: set node bit to 0.
  - Nodes off the path keep their `lru_in` value.
- States: IDLE, WALK, WRITE.
  - IDLE: `update_ready`=1. On `update_req`, capture `update_way` into `way_q`, `lru_in` into `vec_q`, set `node_q`=0 and `level_q`=0, go to WALK.
  - WALK: each cycle, write the node bit per the update rule into `vec_q`. Advance `node_q` to 2·`node_q` + dir + 1 and increment `level_q`. After level `s_width-1` is processed, go to WRITE.
  - WRITE: `lru_we`=1, `done`=1, `lru_out`=`vec_q`; next state IDLE.
- Latency: request accepted in cycle 0 → WALK occupies cycles 1..`s_width` → `lru_we` in cycle `s_width`+1. For `s_assoc`=8 the write is in cycle 4.
- Throughput: one update per `s_width`+2 cycles. `update_ready` is low in WALK and WRITE; `update_req` in those states is ignored, not queued.
- `abort`:
  - In WALK or WRITE: next state IDLE, `lru_we` forced 0 in that same cycle, and no `done`.
  - In IDLE: no effect. If `abort` and `update_req` are both high in IDLE, the request is accepted.
- `node_q` width is `s_width` bits. The leaf index 2p+2 is never stored, because the walk terminates after the last internal level.
- Reset (asynchronous assert, synchronous deassert by the system): state=IDLE; `update_ready`=1 (combinational from state); `lru_we`=0, `done`=0, `lru_out`=0; all internal registers 0. Reset asserted mid-walk discards the update; no write occurs.
- `lru_out` is driven 0 whenever `lru_we`=0.
- `s_assoc`=2: a single WALK cycle; only node 0 is updated.

Test Plan:
- `s_assoc`=8, `lru_in`=7'b0000000, `update_way`=0 → `lru_we` pulse in cycle 4 with `lru_out`=7'b0001011 (nodes 0,1,3 set); `done` high in the same cycle.
- `lru_in`=7'b1111111, `update_way`=7 → `lru_out`=7'b0111010 (nodes 0,2,6 cleared).
- `lru_in`=7'b0000000, `update_way`=5 → `lru_out`=7'b0000100 (only node 2 set; nodes 0 and 5 stay 0).
- Back-to-back `update_req` held high → `update_ready` low in cycles 1–4; second request accepted in cycle 5; exactly one `lru_we` per accepted request.
- `abort` in cycle 2 of a walk → no `lru_we`/`done`; `update_ready`=1 in cycle 3. Repeat with `rst_n` pulsed low mid-walk → outputs 0 immediately, no write.
- Random self-check over 1000 updates: after each write, a victim walk over `lru_out` (child = 2p + bit + 1) never selects `update_way`; untouched node bits equal `lru_in`.

Source files
------------

// File: rtl/plru_tree_update.sv
// Tree-PLRU update walker: on an access, walks root-to-leaf one level per clock,
// points every visited node away from the accessed way, then writes the vector once.
module plru_tree_update #(
  parameter int s_assoc = 8,
  parameter int s_width = $clog2(s_assoc)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               update_req,
  input  logic [s_width-1:0] update_way,
  input  logic [s_assoc-2:0] lru_in,
  input  logic               abort,
  output logic               update_ready,
  output logic [s_assoc-2:0] lru_out,
  output logic               lru_we,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, WALK, WRITE} state_t;

  state_t             state;
  logic [s_width-1:0] way_q;
  logic [s_width-1:0] node_q;
  logic [s_width-1:0] level_q;
  logic [s_assoc-2:0] vec_q;

  logic [s_width-1:0] bit_idx;
  logic               dir;
  logic [s_width:0]   node_wide;
  logic               last_level;

  // Way bits are consumed MSB first, one per tree level.
  assign bit_idx    = s_width'(s_width - 1) - level_q;
  assign dir        = way_q[bit_idx];
  assign node_wide  = {node_q, 1'b0} + {{s_width{1'b0}}, dir} + (s_width + 1)'(1);
  assign last_level = (level_q == s_width'(s_width - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      way_q   <= '0;
      node_q  <= '0;
      level_q <= '0;
      vec_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (update_req) begin
            way_q   <= update_way;
            vec_q   <= lru_in;
            node_q  <= '0;
            level_q <= '0;
            state   <= WALK;
          end
        end
        WALK: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            // Point the node away from the accessed subtree.
            vec_q[node_q] <= ~dir;
            node_q        <= node_wide[s_width-1:0];
            level_q       <= level_q + s_width'(1);
            if (last_level) state <= WRITE;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Abort must suppress the strobe in the same cycle, so the write is gated combinationally.
  assign update_ready = (state == IDLE);
  assign lru_we       = (state == WRITE) && !abort;
  assign done         = lru_we;
  assign lru_out      = lru_we ? vec_q : '0;

endmodule
